// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: state encoding, default width
// and the iteration-counter width helper.
package div_pkg;

    localparam int DEF_WIDTH = 8;

    // 2'd3 is unused and steers back to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        RSVD = 2'd3
    } state_t;

    // Bits needed to hold n-1; never less than 1 so the counter always exists.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/div_sub_stage.sv
// Combinational (WIDTH+1)-bit ripple-borrow subtractor: diff = a - b.
// The LSB is a half-subtractor and every higher bit is a full-subtractor.
module div_sub_stage
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    output logic [WIDTH:0] diff,
    output logic           borrow
);

    logic [WIDTH+1:1] bw;

    // Half-subtractor on bit 0.
    always_comb begin
        diff[0] = a[0] ^ b[0];
        bw[1]   = ~a[0] & b[0];
    end

    // Full-subtractor chain, borrow rippling upward.
    for (genvar i = 1; i <= WIDTH; i++) begin : g_fs
        always_comb begin
            diff[i]  = a[i] ^ b[i] ^ bw[i];
            bw[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
        end
    end

    assign borrow = bw[WIDTH+1];

endmodule

// File: rtl/seq_div_ctrl.sv
// Sequential restoring unsigned divider with valid/ready on both sides.
// One subtractor is reused for WIDTH iterations; a zero divisor short-cuts to DONE.
//
// state | meaning
// IDLE  | in_ready=1, waiting for a request
// RUN   | one quotient bit per cycle, counter runs WIDTH-1 down to 0
// DONE  | out_valid=1, result held until out_ready
module seq_div_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = clog2(WIDTH);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   q, r, d;
    logic [CNT_W-1:0]   cnt;
    logic               dbz;
    logic [WIDTH:0]     diff;
    logic               borrow;
    logic               diff_unused;

    // diff MSB is always 0 when no borrow occurs, because the shifted remainder is < 2*D.
    assign diff_unused = diff[WIDTH];

    div_sub_stage #(.WIDTH(WIDTH)) u_sub (
        .a      ({r, q[WIDTH-1]}),
        .b      ({1'b0, d}),
        .diff   (diff),
        .borrow (borrow)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = (divisor == '0) ? DONE : RUN;
            end
            RUN: begin
                if (cnt == '0) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, restoring iteration, zero-divisor flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= '0;
            r   <= '0;
            d   <= '0;
            cnt <= '0;
            dbz <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (divisor == '0) begin
                            q   <= '1;
                            r   <= dividend;
                            dbz <= 1'b1;
                        end else begin
                            d   <= divisor;
                            q   <= dividend;
                            r   <= '0;
                            cnt <= CNT_W'(WIDTH - 1);
                        end
                    end
                end
                RUN: begin
                    if (!borrow) begin
                        r <= diff[WIDTH-1:0];
                        q <= {q[WIDTH-2:0], 1'b1};
                    end else begin
                        r <= {r[WIDTH-2:0], q[WIDTH-1]};
                        q <= {q[WIDTH-2:0], 1'b0};
                    end
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                end
                DONE: begin
                    if (out_ready) dbz <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign quotient    = q;
    assign remainder   = r;
    assign div_by_zero = dbz;

endmodule

// File: tb/tb_seq_div_ctrl.sv
// Directed and random checks of seq_div_ctrl at WIDTH=8.
module tb_seq_div_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_div_ctrl #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One request: accept, wait for out_valid (bounded), check result and latency,
    // optionally hold backpressure / pulse in_valid during RUN, then handshake.
    task automatic do_div(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er, input logic edbz,
                          input int elat, input int hold, input bit pulse);
        int lat;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        check("in_ready_before_accept", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            if (pulse && lat == 3) begin
                #1;
                in_valid = 1'b1;
                dividend = 8'd1;
                divisor  = 8'd1;
            end else if (pulse && lat == 4) begin
                #1 in_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("latency", lat, elat);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("div_by_zero", div_by_zero, edbz);
        if (!edbz) check("rem_lt_div", remainder < b, 1);
        if (hold > 0) begin
            in_valid = 1'b1;
            dividend = 8'd3;
            divisor  = 8'd0;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_quotient", quotient, eq);
            check("hold_remainder", remainder, er);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        check("post_hs_out_valid", out_valid, 0);
        check("post_hs_in_ready", in_ready, 1);
        check("post_hs_dbz", div_by_zero, 0);
    endtask

    initial begin
        logic [7:0] ra, rb, rq, rr;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        #10 rst_n = 1'b1;

        do_div(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 9, 0, 1'b0);
        do_div(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9, 0, 1'b0);
        do_div(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 9, 0, 1'b0);
        do_div(8'd0, 8'd3, 8'd0, 8'd0, 1'b0, 9, 0, 1'b0);
        do_div(8'd77, 8'd0, 8'hFF, 8'd77, 1'b1, 1, 0, 1'b0);
        do_div(8'd9, 8'd2, 8'd4, 8'd1, 1'b0, 9, 5, 1'b1);
        do_div(8'd13, 8'd0, 8'hFF, 8'd13, 1'b1, 1, 3, 1'b0);

        // Abort mid-RUN with reset.
        @(negedge clk);
        dividend = 8'd200;
        divisor  = 8'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_div(8'd100, 8'd10, 8'd10, 8'd0, 1'b0, 9, 0, 1'b0);

        for (int k = 0; k < 2000; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if (rb == 8'd0) begin
                rq = 8'hFF;
                rr = ra;
            end else begin
                rq = ra / rb;
                rr = ra % rb;
            end
            do_div(ra, rb, rq, rr, rb == 8'd0, (rb == 8'd0) ? 1 : 9, 0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
